// File: rtl/i3c_ccc_pkg.sv
// Shared constants and state encoding for the broadcast-CCC sequencer.
package i3c_ccc_pkg;

    // TX serialiser modes
    localparam logic [2:0] TX_SER = 3'b001;
    localparam logic [2:0] TX_PAR = 3'b011;

    // RX modes
    localparam logic [2:0] RX_ARB = 3'b010;
    localparam logic [2:0] RX_ACK = 3'b000;

    // Regfile location of the 7E+W broadcast header byte
    localparam int BCAST_LOC_DFLT = 46;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_BCAST,
        ST_ACK,
        ST_CCC,
        ST_CCC_T,
        ST_DATA,
        ST_DATA_T,
        ST_FIN
    } ccc_state_e;

endpackage

// File: rtl/ccc_byte_idx.sv
// Data-byte index counter with regfile address adder and last-byte compare.
// The address is built from the index value that will be current next cycle,
// so the registered address lines up with the DATA state it belongs to.
module ccc_byte_idx #(
    parameter int ADDR_W = 10,
    parameter int CNT_W  = 3
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              clr,
    input  logic              inc,
    input  logic [ADDR_W-1:0] base,
    input  logic [CNT_W-1:0]  cnt,
    output logic [ADDR_W-1:0] addr,
    output logic              last
);

    logic [CNT_W-1:0] idx;
    logic [CNT_W-1:0] idx_nxt;

    // Next index: cleared at sequence start, bumped after each data T bit
    always_comb begin
        idx_nxt = idx;
        if (clr) begin
            idx_nxt = '0;
        end else if (inc) begin
            idx_nxt = idx + 1'b1;
        end
    end

    // Index register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            idx <= '0;
        end else begin
            idx <= idx_nxt;
        end
    end

    // Data bytes sit right after the CCC code byte; wraps modulo 2^ADDR_W
    assign addr = base + ADDR_W'(1) + ADDR_W'(idx_nxt);
    assign last = (({1'b0, idx} + 1'b1) == {1'b0, cnt});

endmodule

// File: rtl/ccc_bcast_seq.sv
// Broadcast-CCC sequencer: 7E+W header with arbitration and ACK check, then
// CCC code byte and up to MAX_DATA data bytes, each followed by its T bit.
// Optional macro CCC_RETRY_EN enables bounded NACK retry of the header;
// without it the first NACK ends the sequence with an error.
module ccc_bcast_seq
    import i3c_ccc_pkg::*;
#(
    parameter int ADDR_W    = 10,
    parameter int MAX_DATA  = 4,
    parameter int CNT_W     = 3,
    parameter int RETRY_MAX = 2,
    parameter int BCAST_LOC = BCAST_LOC_DFLT
) (
    input  logic                           i_clk,
    input  logic                           i_rst_n,
    input  logic                           i_i3cengine_en,
    input  logic [ADDR_W-1:0]              i_ccc_addr,
    input  logic [CNT_W-1:0]               i_data_cnt,
    input  logic                           i_tx_mode_done,
    input  logic                           i_rx_mode_done,
    input  logic                           i_rx_ack_nack,
    output logic                           o_regf_rd_en,
    output logic [ADDR_W-1:0]              o_regf_addr,
    output logic                           o_tx_en,
    output logic [2:0]                     o_tx_mode,
    output logic                           o_rx_en,
    output logic [2:0]                     o_rx_mode,
    output logic                           o_i3cengine_done,
    output logic                           o_i3cengine_err,
    output logic [$clog2(RETRY_MAX+1)-1:0] o_retry_cnt
);

    localparam int               RC_W    = $clog2(RETRY_MAX + 1);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_DATA);

    ccc_state_e        state;
    ccc_state_e        state_nxt;
    logic              armed;
    logic [ADDR_W-1:0] ccc_addr_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              start;
    logic              idx_inc;
    logic              fail;
    logic              retry_ok;
    logic [ADDR_W-1:0] data_addr;
    logic              last_byte;

    logic              rd_en_nxt;
    logic [ADDR_W-1:0] addr_nxt;
    logic              tx_en_nxt;
    logic [2:0]        tx_mode_nxt;
    logic              rx_en_nxt;
    logic [2:0]        rx_mode_nxt;
    logic              done_nxt;
    logic              err_nxt;

    ccc_byte_idx #(
        .ADDR_W (ADDR_W),
        .CNT_W  (CNT_W)
    ) u_byte_idx (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .clr     (start),
        .inc     (idx_inc),
        .base    (ccc_addr_q),
        .cnt     (cnt_q),
        .addr    (data_addr),
        .last    (last_byte)
    );

`ifdef CCC_RETRY_EN
    logic [RC_W-1:0] retry_q;

    assign retry_ok    = (retry_q < RC_W'(RETRY_MAX));
    assign o_retry_cnt = retry_q;

    // NACK counter: zero outside a sequence, bumped on each header retry
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            retry_q <= '0;
        end else if (start || (state_nxt == ST_IDLE)) begin
            retry_q <= '0;
        end else if ((state == ST_ACK) && (state_nxt == ST_BCAST)) begin
            retry_q <= retry_q + 1'b1;
        end
    end
`else
    assign retry_ok    = 1'b0;
    assign o_retry_cnt = '0;
`endif

    // Next-state decision; abort (en low) wins over any done input
    always_comb begin
        state_nxt = state;
        start     = 1'b0;
        idx_inc   = 1'b0;
        fail      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (i_i3cengine_en && armed) begin
                    state_nxt = ST_BCAST;
                    start     = 1'b1;
                end
            end
            ST_BCAST: begin
                if (!i_i3cengine_en)     state_nxt = ST_IDLE;
                else if (i_tx_mode_done) state_nxt = ST_ACK;
            end
            ST_ACK: begin
                if (!i_i3cengine_en) begin
                    state_nxt = ST_IDLE;
                end else if (i_rx_mode_done) begin
                    if (!i_rx_ack_nack) begin
                        state_nxt = ST_CCC;
                    end else if (retry_ok) begin
                        state_nxt = ST_BCAST;
                    end else begin
                        state_nxt = ST_FIN;
                        fail      = 1'b1;
                    end
                end
            end
            ST_CCC: begin
                if (!i_i3cengine_en)     state_nxt = ST_IDLE;
                else if (i_tx_mode_done) state_nxt = ST_CCC_T;
            end
            ST_CCC_T: begin
                if (!i_i3cengine_en)     state_nxt = ST_IDLE;
                else if (i_tx_mode_done) state_nxt = (cnt_q == '0) ? ST_FIN : ST_DATA;
            end
            ST_DATA: begin
                if (!i_i3cengine_en)     state_nxt = ST_IDLE;
                else if (i_tx_mode_done) state_nxt = ST_DATA_T;
            end
            ST_DATA_T: begin
                if (!i_i3cengine_en) begin
                    state_nxt = ST_IDLE;
                end else if (i_tx_mode_done) begin
                    idx_inc   = 1'b1;
                    state_nxt = last_byte ? ST_FIN : ST_DATA;
                end
            end
            ST_FIN:  state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Output values for the state being entered; registered below
    always_comb begin
        rd_en_nxt   = 1'b0;
        addr_nxt    = '0;
        tx_en_nxt   = 1'b0;
        tx_mode_nxt = 3'b000;
        rx_en_nxt   = 1'b0;
        rx_mode_nxt = 3'b000;
        done_nxt    = 1'b0;
        err_nxt     = 1'b0;
        case (state_nxt)
            ST_BCAST: begin
                rd_en_nxt   = 1'b1;
                addr_nxt    = ADDR_W'(BCAST_LOC);
                tx_en_nxt   = 1'b1;
                tx_mode_nxt = TX_SER;
                rx_en_nxt   = 1'b1;
                rx_mode_nxt = RX_ARB;
            end
            ST_ACK: begin
                rx_en_nxt   = 1'b1;
                rx_mode_nxt = RX_ACK;
            end
            ST_CCC: begin
                rd_en_nxt   = 1'b1;
                addr_nxt    = ccc_addr_q;
                tx_en_nxt   = 1'b1;
                tx_mode_nxt = TX_SER;
            end
            ST_DATA: begin
                rd_en_nxt   = 1'b1;
                addr_nxt    = data_addr;
                tx_en_nxt   = 1'b1;
                tx_mode_nxt = TX_SER;
            end
            ST_CCC_T, ST_DATA_T: begin
                tx_en_nxt   = 1'b1;
                tx_mode_nxt = TX_PAR;
            end
            ST_FIN: begin
                done_nxt = 1'b1;
                err_nxt  = fail;
            end
            default: ;
        endcase
    end

    // State and arm flag; arm re-sets whenever en is seen low
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= ST_IDLE;
            armed <= 1'b1;
        end else begin
            state <= state_nxt;
            if (!i_i3cengine_en) begin
                armed <= 1'b1;
            end else if (start) begin
                armed <= 1'b0;
            end
        end
    end

    // Sequence parameters captured at start; count clamped to MAX_DATA
    always_ff @(posedge i_clk) begin
        if (start) begin
            ccc_addr_q <= i_ccc_addr;
            cnt_q      <= (i_data_cnt > MAX_CNT) ? MAX_CNT : i_data_cnt;
        end
    end

    // Registered outputs
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_regf_rd_en     <= 1'b0;
            o_regf_addr      <= '0;
            o_tx_en          <= 1'b0;
            o_tx_mode        <= 3'b000;
            o_rx_en          <= 1'b0;
            o_rx_mode        <= 3'b000;
            o_i3cengine_done <= 1'b0;
            o_i3cengine_err  <= 1'b0;
        end else begin
            o_regf_rd_en     <= rd_en_nxt;
            o_regf_addr      <= addr_nxt;
            o_tx_en          <= tx_en_nxt;
            o_tx_mode        <= tx_mode_nxt;
            o_rx_en          <= rx_en_nxt;
            o_rx_mode        <= rx_mode_nxt;
            o_i3cengine_done <= done_nxt;
            o_i3cengine_err  <= err_nxt;
        end
    end

endmodule

// File: tb/tb_ccc_bcast_seq.sv
// Directed bench for ccc_bcast_seq (default parameters). Outputs are packed as
// {rd_en, addr[9:0], tx_en, tx_mode[2:0], rx_en, rx_mode[2:0], done, err}.
module tb_ccc_bcast_seq;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic [9:0] ccc_addr;
    logic [2:0] data_cnt;
    logic       tx_done;
    logic       rx_done;
    logic       nack;
    logic       rd_en;
    logic [9:0] addr;
    logic       tx_en;
    logic [2:0] tx_mode;
    logic       rx_en;
    logic [2:0] rx_mode;
    logic       done;
    logic       err;
    logic [1:0] retry_cnt;
    logic [20:0] obs;

    int n_cmp = 0;
    int n_bad = 0;

    localparam logic [20:0] V_IDLE  = 21'd0;
    localparam logic [20:0] V_BCAST = {1'b1, 10'd46, 1'b1, 3'b001, 1'b1, 3'b010, 1'b0, 1'b0};
    localparam logic [20:0] V_ACK   = {1'b0, 10'd0, 1'b0, 3'b000, 1'b1, 3'b000, 1'b0, 1'b0};
    localparam logic [20:0] V_T     = {1'b0, 10'd0, 1'b1, 3'b011, 1'b0, 3'b000, 1'b0, 1'b0};
    localparam logic [20:0] V_FIN   = {1'b0, 10'd0, 1'b0, 3'b000, 1'b0, 3'b000, 1'b1, 1'b0};
    localparam logic [20:0] V_FERR  = {1'b0, 10'd0, 1'b0, 3'b000, 1'b0, 3'b000, 1'b1, 1'b1};

    always #5 clk = ~clk;

    ccc_bcast_seq dut (
        .i_clk            (clk),
        .i_rst_n          (rst_n),
        .i_i3cengine_en   (en),
        .i_ccc_addr       (ccc_addr),
        .i_data_cnt       (data_cnt),
        .i_tx_mode_done   (tx_done),
        .i_rx_mode_done   (rx_done),
        .i_rx_ack_nack    (nack),
        .o_regf_rd_en     (rd_en),
        .o_regf_addr      (addr),
        .o_tx_en          (tx_en),
        .o_tx_mode        (tx_mode),
        .o_rx_en          (rx_en),
        .o_rx_mode        (rx_mode),
        .o_i3cengine_done (done),
        .o_i3cengine_err  (err),
        .o_retry_cnt      (retry_cnt)
    );

    assign obs = {rd_en, addr, tx_en, tx_mode, rx_en, rx_mode, done, err};

    function automatic logic [20:0] v_rd(input logic [9:0] a);
        return {1'b1, a, 1'b1, 3'b001, 1'b0, 3'b000, 1'b0, 1'b0};
    endfunction

    task automatic chk(input string tag, input logic [20:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h required %h", tag, obs, exp);
        end
    endtask

    task automatic chk_rc(input string tag, input logic [1:0] exp);
        n_cmp++;
        assert (retry_cnt === exp) else begin
            n_bad++;
            $error("FAIL %s: observed retry_cnt %0d required %0d", tag, retry_cnt, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_tx();
        tx_done = 1'b1;
        step();
        tx_done = 1'b0;
    endtask

    task automatic pulse_rx(input logic n);
        rx_done = 1'b1;
        nack    = n;
        step();
        rx_done = 1'b0;
        nack    = 1'b0;
    endtask

    task automatic rearm();
        en = 1'b0;
        step();
    endtask

    task automatic run_to_ccc(input logic [9:0] a, input logic [2:0] c);
        ccc_addr = a;
        data_cnt = c;
        en       = 1'b1;
        step();
        chk("start_bcast", V_BCAST);
        pulse_tx();
        chk("start_ack", V_ACK);
        pulse_rx(1'b0);
        chk("start_ccc", v_rd(a));
    endtask

    initial begin
        rst_n    = 1'b0;
        en       = 1'b0;
        ccc_addr = '0;
        data_cnt = '0;
        tx_done  = 1'b0;
        rx_done  = 1'b0;
        nack     = 1'b0;
        #2;
        chk("reset_outputs", V_IDLE);
        chk_rc("reset_retry", 2'd0);
        step();
        step();
        rst_n = 1'b1;
        step();
        chk("idle_after_reset", V_IDLE);

        // cnt=0 with ACK, then en held high after FIN
        run_to_ccc(10'd50, 3'd0);
        pulse_tx();
        chk("t1_ccc_t", V_T);
        pulse_tx();
        chk("t1_fin", V_FIN);
        step();
        chk("t1_idle", V_IDLE);
        step();
        step();
        chk("t1_no_restart", V_IDLE);
        rearm();

        // three data bytes at 61..63
        run_to_ccc(10'd60, 3'd3);
        pulse_tx();
        chk("t2_ccc_t", V_T);
        for (int i = 0; i < 3; i++) begin
            pulse_tx();
            chk("t2_data", v_rd(10'(61 + i)));
            pulse_tx();
            chk("t2_data_t", V_T);
        end
        pulse_tx();
        chk("t2_fin", V_FIN);
        rearm();
        chk("t2_idle", V_IDLE);

`ifdef CCC_RETRY_EN
        // NACK, NACK, ACK
        ccc_addr = 10'd70;
        data_cnt = 3'd0;
        en       = 1'b1;
        step();
        chk("t3_bcast1", V_BCAST);
        pulse_tx();
        chk("t3_ack1", V_ACK);
        pulse_rx(1'b1);
        chk("t3_bcast2", V_BCAST);
        chk_rc("t3_retry1", 2'd1);
        pulse_tx();
        chk("t3_ack2", V_ACK);
        pulse_rx(1'b1);
        chk("t3_bcast3", V_BCAST);
        chk_rc("t3_retry2", 2'd2);
        pulse_tx();
        chk("t3_ack3", V_ACK);
        pulse_rx(1'b0);
        chk("t3_ccc", v_rd(10'd70));
        chk_rc("t3_retry_hold", 2'd2);
        pulse_tx();
        chk("t3_ccc_t", V_T);
        pulse_tx();
        chk("t3_fin_ok", V_FIN);
        step();
        chk_rc("t3_retry_clr", 2'd0);
        rearm();

        // NACK three times
        en = 1'b1;
        step();
        chk("t4_bcast", V_BCAST);
        for (int i = 0; i < 3; i++) begin
            pulse_tx();
            chk("t4_ack", V_ACK);
            pulse_rx(1'b1);
            if (i < 2) chk("t4_rebcast", V_BCAST);
            else       chk("t4_fin_err", V_FERR);
        end
        step();
        chk("t4_idle", V_IDLE);
        chk_rc("t4_retry_clr", 2'd0);
        rearm();
`else
        // first NACK ends the sequence with error
        ccc_addr = 10'd70;
        data_cnt = 3'd0;
        en       = 1'b1;
        step();
        chk("t3_bcast", V_BCAST);
        pulse_tx();
        chk("t3_ack", V_ACK);
        pulse_rx(1'b1);
        chk("t3_fin_err", V_FERR);
        chk_rc("t3_retry_zero", 2'd0);
        step();
        chk("t3_idle", V_IDLE);
        rearm();
`endif

        // abort during DATA
        run_to_ccc(10'd100, 3'd2);
        pulse_tx();
        chk("t5_ccc_t", V_T);
        pulse_tx();
        chk("t5_data", v_rd(10'd101));
        en = 1'b0;
        step();
        chk("t5_abort_idle", V_IDLE);
        step();
        chk("t5_no_done", V_IDLE);

        // address wrap 1022 -> 1023, 0
        run_to_ccc(10'd1022, 3'd2);
        pulse_tx();
        chk("t6_ccc_t", V_T);
        pulse_tx();
        chk("t6_data_1023", v_rd(10'd1023));
        pulse_tx();
        chk("t6_data_t0", V_T);
        pulse_tx();
        chk("t6_data_0", v_rd(10'd0));
        pulse_tx();
        chk("t6_data_t1", V_T);
        pulse_tx();
        chk("t6_fin", V_FIN);
        rearm();

        // cnt=7 clamps to 4 bytes at 201..204
        run_to_ccc(10'd200, 3'd7);
        pulse_tx();
        chk("t7_ccc_t", V_T);
        for (int i = 0; i < 4; i++) begin
            pulse_tx();
            chk("t7_data", v_rd(10'(201 + i)));
            pulse_tx();
            chk("t7_data_t", V_T);
        end
        pulse_tx();
        chk("t7_fin", V_FIN);
        rearm();

        // async reset in CCC_T
        run_to_ccc(10'd300, 3'd1);
        pulse_tx();
        chk("t8_ccc_t", V_T);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t8_async_reset", V_IDLE);
        en = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        chk("t8_idle_after", V_IDLE);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ccc_bcast_seq.md
# ccc_bcast_seq

Parametrised broadcast-CCC sequencer for the I3C engine, and the generalised successor of the fixed ENTHDR sequencer. It arbitrates and sends the 7E+W broadcast header, then checks ACK. It then serialises a CCC code byte and 0..MAX_DATA defining/data bytes, all fetched from the register file, each followed by its T (parity) bit. NACK handling has bounded retry, and an error flag reports failed transfers. It sits between the I3C engine top FSM and the shared TX/RX serialiser blocks and regfile read port.

## Interface
Parameters:
- ADDR_W, 10, regfile address width
- MAX_DATA, 4, maximum data bytes following the CCC code
- CNT_W, 3, width of data-count input (must hold MAX_DATA)
- RETRY_MAX, 2, broadcast re-attempts after NACK
- BCAST_LOC, 46, regfile location of the 7E+W byte

Ports:
- i_clk  in  1  system clock
- i_rst_n  in  1  asynchronous, active-low reset
- i_i3cengine_en  in  1  level request; a sequence starts only on an armed rising condition (see Operation)
- i_ccc_addr  in  ADDR_W  regfile address of CCC code byte; data bytes follow contiguously
- i_data_cnt  in  CNT_W  number of data bytes (0..MAX_DATA)
- i_tx_mode_done  in  1  TX finished current mode (byte or T bit)
- i_rx_mode_done  in  1  RX finished ACK sampling
- i_rx_ack_nack  in  1  0 = ACK, 1 = NACK; valid with i_rx_mode_done
- o_regf_rd_en  out  1  regfile read enable
- o_regf_addr  out  ADDR_W  regfile read address
- o_tx_en  out  1  TX enable
- o_tx_mode  out  3  001 serialise, 011 parity/T bit
- o_rx_en  out  1  RX enable
- o_rx_mode  out  3  010 arbitration, 000 ACK
- o_i3cengine_done  out  1  one-cycle pulse at sequence end (success or error)
- o_i3cengine_err  out  1  one-cycle pulse, coincident with done, on final NACK
- o_retry_cnt  out  $clog2(RETRY_MAX+1)  NACKs seen in current sequence

## Operation
- States: IDLE, BCAST, ACK, CCC, CCC_T, DATA, DATA_T, FIN.
- IDLE: all outputs at reset value.
  - If en=1 and armed: latch i_ccc_addr, latch min(i_data_cnt, MAX_DATA), clear idx and retry count, then go to BCAST.
  - Armed sets when en is seen low and clears on start. Level-high en never restarts back-to-back.
- BCAST: rd_en=1, addr=BCAST_LOC, tx_en=1 mode 001, rx_en=1 mode 010. On tx_mode_done go to ACK.
- ACK: tx_en=0, rx_en=1 mode 000. On rx_mode_done:
  - ACK goes to CCC.
  - NACK with retry<RETRY_MAX: retry++, back to BCAST.
  - Otherwise go to FIN with err.
- CCC: addr=latched ccc_addr, tx mode 001. On tx_mode_done go to CCC_T.
- CCC_T: tx mode 011. On tx_mode_done go to FIN if cnt==0, else DATA.
- DATA: addr=ccc_addr+1+idx (modulo 2^ADDR_W), tx mode 001. On tx_mode_done go to DATA_T.
- DATA_T: tx mode 011. On tx_mode_done: idx++; go to FIN if idx+1==cnt, else DATA.
- FIN: done=1 (err=1 if NACK-terminated), all enables 0. Go to IDLE next cycle.
- Abort: en low in any non-IDLE, non-FIN state goes to IDLE next cycle with outputs at reset value. No done or err is produced.
- Simultaneous events: abort has priority over tx_mode_done and rx_mode_done. Done inputs are ignored in states that do not wait on them.

## Timing
- All outputs are registered. Outputs for a state appear the cycle after the transition decision.
- Reset values: every output is 0; state=IDLE; armed=1.
- Start latency: en rising to BCAST outputs is 1 cycle.
- Each done input causes its transition on the edge where it is sampled high. New mode outputs are visible the next cycle.
- Reset mid-operation: immediate return to IDLE with all outputs at 0.

## Configuration
- CCC_RETRY_EN defined: NACK retry up to RETRY_MAX as above.
- CCC_RETRY_EN undefined: the first NACK goes directly to FIN with err. o_retry_cnt is tied to 0 and the retry counter is not synthesised.

## Structure
- Shared package i3c_ccc_pkg holds:
  - TX mode constants (SER=3'b001, PAR=3'b011)
  - RX mode constants (ARB=3'b010, ACK=3'b000)
  - state enum typedef
  - BCAST_LOC default
- Optional sub-module ccc_byte_idx: data-index counter plus address adder, with last-byte compare.

## Test plan
- Defaults, ccc_addr=50, cnt=0, ACK: sequence BCAST(addr 46) → ACK → CCC(addr 50) → CCC_T → FIN. Exactly one done pulse; err=0.
- ccc_addr=60, cnt=3: data reads at addr 61, 62, 63. Each is followed by tx mode 011. Done pulses after the third T bit.
- NACK twice then ACK, CCC_RETRY_EN defined: three BCAST passes, retry_cnt=2, then normal completion with err=0.
- NACK three times: done=1 and err=1 in the same cycle. Without CCC_RETRY_EN, the same result follows the first NACK.
- Tests for aborts and address limits:
  - en dropped during DATA: IDLE next cycle, all outputs 0, no done.
  - en held high after FIN: no restart until en toggles low.
- Boundaries:
  - ccc_addr=1022, cnt=2: data reads at addresses 1023 and 0.
  - cnt=7: clamped to 4 data bytes.
  - Async reset asserted mid-CCC_T: all outputs 0 immediately.
